conv_via_tiling_mul_pipe: RTL

Parametrised, pipelined successor to the combinational HLS multiplier core used in conv_via_tiling. It computes din0*din1 with per-operand signedness selection over a configurable number of register stages, and has an optional accumulate mode for tile dot-products. A valid/ready handshake with whole-pipeline stall replaces the free-running combinational path. It sits between the tile operand fetch and the conv accumulation buffer.

---
 rtl/conv_via_tiling_mul_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/conv_via_tiling_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, optional running-sum accumulate
// and a valid/ready handshake that stalls the whole pipeline like an HLS clock enable.
module conv_via_tiling_mul_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_WIDTH  = 32,
  parameter int DIN1_WIDTH  = 36,
  parameter int DOUT_WIDTH  = 68,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout
);

  localparam int PW         = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int PD         = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam bit ANY_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_cfg
    $error("conv_via_tiling_mul_pipe[%0d]: NUM_STAGE must be 1..8", ID);
  end

  logic                  adv;
  logic                  accept;
  logic                  out_valid_q;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic [DOUT_WIDTH-1:0] acc_q;

  // Operands feeding the final stage: straight from the ports, or from the last pipe register.
  logic [DIN0_WIDTH-1:0] f_din0;
  logic [DIN1_WIDTH-1:0] f_din1;
  logic                  f_acc;
  logic                  f_vld;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

  if (NUM_STAGE == 1) begin : g_direct
    assign f_din0 = din0;
    assign f_din1 = din1;
    assign f_acc  = acc;
    assign f_vld  = accept;
  end else begin : g_pipe
    logic [DIN0_WIDTH-1:0] din0_q [PD];
    logic [DIN1_WIDTH-1:0] din1_q [PD];
    logic [PD-1:0]         acc_bit_q;
    logic [PD-1:0]         vld_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        vld_q <= '0;
      end else if (adv) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
        vld_q[0] <= accept;
        for (int i = 1; i < PD; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    // NOTE: payload registers carry no reset; the reset valid bits already mark them as garbage.
    always_ff @(posedge ap_clk) begin
      if (adv) begin
        din0_q[0]    <= din0;
        din1_q[0]    <= din1;
        acc_bit_q[0] <= acc;
        for (int i = 1; i < PD; i++) begin
          din0_q[i]    <= din0_q[i-1];
          din1_q[i]    <= din1_q[i-1];
          acc_bit_q[i] <= acc_bit_q[i-1];
        end
      end
    end

    assign f_din0 = din0_q[PD-1];
    assign f_din1 = din1_q[PD-1];
    assign f_acc  = acc_bit_q[PD-1];
    assign f_vld  = vld_q[PD-1];
  end

  logic signed [PW-1:0]   op0_x;
  logic signed [PW-1:0]   op1_x;
  logic signed [PW-1:0]   prod_x;
  logic [DOUT_WIDTH-1:0]  prod;
  logic [DOUT_WIDTH-1:0]  res;

  // NOTE: every combinational output is assigned on all paths so no latch is inferred.
  always_comb begin
    op0_x  = {{(PW-DIN0_WIDTH){(DIN0_SIGNED != 0) && f_din0[DIN0_WIDTH-1]}}, f_din0};
    op1_x  = {{(PW-DIN1_WIDTH){(DIN1_SIGNED != 0) && f_din1[DIN1_WIDTH-1]}}, f_din1};
    prod_x = op0_x * op1_x;
  end

  if (DOUT_WIDTH <= PW) begin : g_trunc
    assign prod = prod_x[DOUT_WIDTH-1:0];
  end else if (ANY_SIGNED) begin : g_sext
    assign prod = DOUT_WIDTH'(prod_x);
  end else begin : g_zext
    assign prod = DOUT_WIDTH'($unsigned(prod_x));
  end

  // Running sum wraps modulo 2^DOUT_WIDTH.
  assign res = f_acc ? acc_q + prod : prod;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      acc_q       <= '0;
    end else if (adv) begin
      out_valid_q <= f_vld;
      if (f_vld) begin
        dout_q <= res;
        acc_q  <= res;
      end
    end
  end

endmodule
